// File: rtl/timebase_controller_if.sv
// Divisor offer handshake between the control FSM and the timebase.
// Master offers div_value with div_valid; slave answers with div_ready.
interface timebase_controller_if #(
  parameter int unsigned CNT_WIDTH = 28
) ();

  logic                 div_valid;
  logic [CNT_WIDTH-1:0] div_value;
  logic                 div_ready;

  modport master (
    output div_valid,
    output div_value,
    input  div_ready
  );

  modport slave (
    input  div_valid,
    input  div_value,
    output div_ready
  );

endinterface

// File: rtl/timebase_controller.sv
// Run/pause/clear sequencer owning the divide counter of the timebase.
// Define PHASE_ALIGN_EN to apply new divisors at once with a phase restart.
module timebase_controller #(
  parameter int unsigned          CNT_WIDTH   = 28,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV = CNT_WIDTH'(500000)
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  timebase_controller_if.slave div_if,
  output logic                 tick,
  output logic                 clock_out,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] div_active,
  output logic                 err_div
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] div_q;
  logic                 err_q;

  logic [CNT_WIDTH-1:0] last;
  logic [CNT_WIDTH-1:0] half;
  logic                 at_wrap;
  logic                 hs;
  logic                 hs_ok;
  logic                 hs_bad;

  assign last    = div_q - ONE;
  assign half    = div_q >> 1;
  assign at_wrap = (state_q == RUN) && (cnt_q >= last);
  assign hs      = div_if.div_valid && div_if.div_ready;
  assign hs_ok   = hs && (div_if.div_value >= TWO);
  assign hs_bad  = hs && (div_if.div_value < TWO);

`ifdef PHASE_ALIGN_EN

  assign div_if.div_ready = 1'b1;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DEFAULT_DIV;
      err_q   <= 1'b0;
    end else begin
      err_q <= hs_bad;

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!clear && !stop && start)
            state_q <= RUN;
        end
        RUN: begin
          cnt_q <= at_wrap ? '0 : cnt_q + ONE;
          if (clear)
            state_q <= IDLE;
          else if (stop)
            state_q <= PAUSE;
        end
        PAUSE: begin
          if (clear)
            state_q <= IDLE;
          else if (!stop && start)
            state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase

      // New divisor restarts the period from zero.
      if (hs_ok) begin
        div_q <= div_if.div_value;
        cnt_q <= '0;
      end

      if (clear)
        cnt_q <= '0;
    end
  end

`else

  logic [CNT_WIDTH-1:0] pend_q;
  logic                 pend_vld_q;

  assign div_if.div_ready = !pend_vld_q;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= DEFAULT_DIV;
      err_q      <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      err_q <= hs_bad;

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!clear && !stop && start)
            state_q <= RUN;
        end
        RUN: begin
          cnt_q <= at_wrap ? '0 : cnt_q + ONE;
          if (clear)
            state_q <= IDLE;
          else if (stop)
            state_q <= PAUSE;
        end
        PAUSE: begin
          if (clear)
            state_q <= IDLE;
          else if (!stop && start)
            state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase

      // Pending divisor lands on the wrap edge so no period is cut short.
      if (at_wrap && pend_vld_q) begin
        div_q      <= pend_q;
        pend_vld_q <= 1'b0;
      end

      if (hs_ok) begin
        if (state_q == IDLE || clear) begin
          div_q <= div_if.div_value;
        end else begin
          pend_q     <= div_if.div_value;
          pend_vld_q <= 1'b1;
        end
      end

      if (clear) begin
        cnt_q <= '0;
        if (pend_vld_q) begin
          div_q      <= pend_q;
          pend_vld_q <= 1'b0;
        end
      end
    end
  end

`endif

  assign tick       = (state_q == RUN) && (cnt_q == last);
  assign clock_out  = (state_q != IDLE) && (cnt_q >= half);
  assign running    = (state_q == RUN);
  assign div_active = div_q;
  assign err_div    = err_q;

endmodule

// File: tb/tb_timebase_controller.sv
// Directed bench for timebase_controller with a tick-cycle scoreboard.
// Expected tick cycles are queued by stimulus and popped by the monitor.
module tb_timebase_controller;

  localparam int unsigned CW = 28;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stop;
  logic          clear;
  logic          tick;
  logic          clock_out;
  logic          running;
  logic [CW-1:0] div_active;
  logic          err_div;

  int checks;
  int failures;
  int cyc;
  int exp_q[$];

  timebase_controller_if #(.CNT_WIDTH(CW)) dif ();

  timebase_controller #(
    .CNT_WIDTH  (CW),
    .DEFAULT_DIV(28'd10)
  ) dut (
    .clock_in  (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .div_if    (dif),
    .tick      (tick),
    .clock_out (clock_out),
    .running   (running),
    .div_active(div_active),
    .err_div   (err_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every tick must match the head of the expected queue.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tick_unexpected actual=%0d required=none", cyc);
      end else begin
        chk("tick_cycle", cyc, exp_q.pop_front());
      end
    end else if (exp_q.size() != 0 && exp_q[0] < cyc) begin
      checks++;
      failures++;
      $display("FAIL tick_missed actual=none required=%0d",
               exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(output int s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic offer(input logic [CW-1:0] v);
    dif.div_valid = 1'b1;
    dif.div_value = v;
    @(negedge clk);
    dif.div_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int s;
    int r;
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    start         = 1'b0;
    stop          = 1'b0;
    clear         = 1'b0;
    dif.div_valid = 1'b0;
    dif.div_value = '0;
    repeat (3) @(negedge clk);
    chk("rst_div_ready", dif.div_ready, 1);
    chk("rst_tick", tick, 0);
    chk("rst_clock_out", clock_out, 0);
    chk("rst_running", running, 0);
    chk("rst_err_div", err_div, 0);
    chk("rst_div_active", div_active, 10);
    reset = 1'b0;
    @(negedge clk);

    // Default divisor 10
    pulse_start(s);
    exp_q.push_back(s + 9);
    exp_q.push_back(s + 19);
    exp_q.push_back(s + 29);
    chk("t1_running", running, 1);
    for (int k = 1; k <= 10; k++) begin
      chk("t1_clock_out", clock_out, (k > 5) ? 1 : 0);
      @(negedge clk);
    end
    wait_cyc(s + 30);
    do_clear();
    chk("t1_clr_running", running, 0);
    chk("t1_clr_clock_out", clock_out, 0);

    // Divisor 7 loaded in IDLE
    offer(28'd7);
    chk("t2_div_active", div_active, 7);
    pulse_start(s);
    exp_q.push_back(s + 6);
    exp_q.push_back(s + 13);
    exp_q.push_back(s + 20);
    for (int k = 1; k <= 7; k++) begin
      chk("t2_clock_out", clock_out, (k > 3) ? 1 : 0);
      @(negedge clk);
    end
    wait_cyc(s + 21);
    do_clear();

    // Divisor 4 offered mid-period with D=10
    offer(28'd10);
    chk("t3_div_active0", div_active, 10);
    pulse_start(s);
    wait_cyc(s + 2);
    chk("t3_ready_pre", dif.div_ready, 1);
    offer(28'd4);
`ifdef PHASE_ALIGN_EN
    chk("t3_ready_post", dif.div_ready, 1);
    chk("t3_div_now", div_active, 4);
    exp_q.push_back(s + 6);
    exp_q.push_back(s + 10);
    exp_q.push_back(s + 14);
    exp_q.push_back(s + 18);
`else
    chk("t3_ready_post", dif.div_ready, 0);
    chk("t3_div_held", div_active, 10);
    exp_q.push_back(s + 9);
    exp_q.push_back(s + 13);
    exp_q.push_back(s + 17);
    wait_cyc(s + 9);
    chk("t3_ready_wrap", dif.div_ready, 0);
    @(negedge clk);
    chk("t3_ready_after", dif.div_ready, 1);
    chk("t3_div_after", div_active, 4);
`endif
    wait_cyc(s + 18);
    do_clear();

    // Pause at counter 6 for 20 cycles, then resume
    offer(28'd10);
    pulse_start(s);
    wait_cyc(s + 6);
    stop = 1'b1;
    @(negedge clk);
    chk("t4_paused_running", running, 0);
    chk("t4_paused_clk", clock_out, 1);
    repeat (19) @(negedge clk);
    chk("t4_held_clk", clock_out, 1);
    stop  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r = cyc;
    exp_q.push_back(r + 2);
    exp_q.push_back(r + 12);
    chk("t4_resumed", running, 1);

    // start+stop together in RUN, then clear with stop
    wait_cyc(r + 19);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("t5_both_running", running, 0);
    chk("t5_both_clk", clock_out, 1);
    clear = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    stop  = 1'b0;
    chk("t5_clr_running", running, 0);
    chk("t5_clr_clk", clock_out, 0);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("t5_idle_both", running, 0);
    pulse_start(s);
    exp_q.push_back(s + 9);
    wait_cyc(s + 10);
    do_clear();

    // Illegal divisor
    dif.div_valid = 1'b1;
    dif.div_value = 28'd1;
    chk("t6_ready", dif.div_ready, 1);
    @(negedge clk);
    dif.div_valid = 1'b0;
    chk("t6_err_pulse", err_div, 1);
    chk("t6_div_kept", div_active, 10);
    @(negedge clk);
    chk("t6_err_end", err_div, 0);
    chk("t6_ready_end", dif.div_ready, 1);

    // Asynchronous reset mid-period with a pending divisor
    offer(28'd7);
    pulse_start(s);
    exp_q.push_back(s + 6);
`ifndef PHASE_ALIGN_EN
    wait_cyc(s + 2);
    offer(28'd9);
    chk("t7_ready_pend", dif.div_ready, 0);
`endif
    wait_cyc(s + 6);
    chk("t7_tick_high", tick, 1);
    chk("t7_clk_high", clock_out, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_rst_tick", tick, 0);
    chk("t7_rst_clk", clock_out, 0);
    chk("t7_rst_running", running, 0);
    chk("t7_rst_ready", dif.div_ready, 1);
    chk("t7_rst_div", div_active, 10);
    chk("t7_rst_err", err_div, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_post_running", running, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
